// File: rtl/instr_fetch_unit.sv
// Single-cycle fetch stage: PC, instruction memory and IDLE/RUN/HALT control.
// Define IFU_PERF_CNT_EN to build the instret/taken performance counters.
module instr_fetch_unit #(
  parameter int          IMEM_DEPTH = 64,
  parameter logic [31:0] RESET_PC   = 32'h0000_0000
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          imem_we,
  input  logic [$clog2(IMEM_DEPTH)-1:0] imem_waddr,
  input  logic [31:0]                   imem_wdata,
  input  logic                          start,
  input  logic                          stall,
  input  logic                          branch,
  input  logic                          bne,
  input  logic                          jump,
  input  logic                          zero,
  output logic [31:0]                   pc,
  output logic [31:0]                   pc_plus4,
  output logic [31:0]                   instruction,
  output logic                          instr_valid,
  output logic                          halted,
  output logic                          fault,
  output logic [31:0]                   instret_count,
  output logic [31:0]                   taken_count
);

  localparam int ADDR_W = $clog2(IMEM_DEPTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        fault_q, fault_d;
  logic        valid_q, valid_d;
  logic        halted_q, halted_d;

  logic [31:0] imem [IMEM_DEPTH];

  logic              run;
  logic              in_range;
  logic              oor;
  logic              is_halt;
  logic              adv;
  logic              retire;
  logic              br_taken;
  logic [ADDR_W-1:0] rd_idx;
  logic [31:0]       br_target;
  logic [31:0]       j_target;

  assign run      = (state_q == RUN);
  assign rd_idx   = pc_q[ADDR_W+1:2];
  assign in_range = (pc_q[31:ADDR_W+2] == '0);
  assign oor      = run && !in_range;

  assign instruction = (run && in_range) ? imem[rd_idx] : 32'h0;
  assign pc          = pc_q;
  assign pc_plus4    = pc_q + 32'd4;

  assign is_halt  = run && in_range && (instruction[31:26] == 6'h3F);
  assign adv      = run && !stall;
  assign retire   = adv && !is_halt && !oor;
  assign br_taken = branch && (zero ^ bne);

  assign j_target  = {pc_plus4[31:28], instruction[25:0], 2'b00};
  assign br_target = pc_plus4 +
                     {{14{instruction[15]}}, instruction[15:0], 2'b00};

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    fault_d = fault_q | oor;
    unique case (state_q)
      IDLE: begin
        if (start) state_d = RUN;
      end
      RUN: begin
        if (adv) begin
          if (!retire)       state_d = HALT;
          else if (jump)     pc_d    = j_target;
          else if (br_taken) pc_d    = br_target;
          else               pc_d    = pc_plus4;
        end
      end
      HALT: begin
        state_d = HALT;
      end
      default: state_d = IDLE;
    endcase
    valid_d  = (state_d == RUN);
    halted_d = (state_d == HALT);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      pc_q     <= RESET_PC;
      fault_q  <= 1'b0;
      valid_q  <= 1'b0;
      halted_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      fault_q  <= fault_d;
      valid_q  <= valid_d;
      halted_q <= halted_d;
    end
  end

  // Program memory is not reset so a loaded program survives reset.
  always_ff @(posedge clk) begin
    if (state_q == IDLE && imem_we) begin
      imem[imem_waddr] <= imem_wdata;
    end
  end

  assign instr_valid = valid_q;
  assign halted      = halted_q;
  assign fault       = fault_q | oor;

`ifdef IFU_PERF_CNT_EN
  logic        redirect;
  logic [31:0] instret_q, instret_d;
  logic [31:0] taken_q, taken_d;

  assign redirect = retire && (jump || br_taken);

  always_comb begin
    instret_d = instret_q + {31'b0, retire};
    taken_d   = taken_q + {31'b0, redirect};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      instret_q <= 32'h0;
      taken_q   <= 32'h0;
    end else begin
      instret_q <= instret_d;
      taken_q   <= taken_d;
    end
  end

  assign instret_count = instret_q;
  assign taken_count   = taken_q;
`else
  assign instret_count = 32'h0;
  assign taken_count   = 32'h0;
`endif

endmodule
